cart_cmd_ctrl: RTL and testbench
================================

Name: cart_cmd_ctrl

Overview:
- Command sequencer that sits downstream of the UART receiver in the Bluetooth cart.
- Consumes received bytes (rx_data plus the rx_ready strobe from the baud8clk domain) and parses fixed 4-byte command frames.
- Drives left/right motor direction and speed registers.
- A link watchdog forces the cart to stop when valid frames stop arriving.

Parameters:
- TIMEOUT_CYCLES, 50000000: clk cycles without a valid frame before a forced stop (1 s at 50 MHz).
- GAP_CYCLES, 5000000: maximum clk cycles between bytes of one frame before the frame is abandoned.
- CNT_W, 26: width of the watchdog and gap counters. Must hold both TIMEOUT_CYCLES and GAP_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- rx_data  in  8  received byte from the UART receiver; stable while rx_ready is high.
- rx_ready  in  1  byte-done flag from the receiver; asynchronous to clk.
- dir_l  out  1  left motor direction (1 = forward).
- dir_r  out  1  right motor direction (1 = forward).
- speed_l  out  8  left motor duty.
- speed_r  out  8  right motor duty.
- cmd_valid  out  1  one-cycle pulse when a valid frame is executed.
- frame_err  out  1  one-cycle pulse on a bad checksum or an unknown command.
- timeout  out  1  high while the watchdog stop is in force.

Behaviour:
- Reset (rst=0 at a clk edge):
  - FSM to IDLE; all counters cleared; synchronizer flops cleared.
  - All outputs go to 0, except timeout, which also resets to 0.
- Input capture:
  - rx_ready passes through a 3-flop chain s1→s2→s3. The byte strobe is s2 & ~s3.
  - rx_data is captured on the strobe cycle.
  - If rx_ready is first sampled high at edge k, the FSM consumes the byte at edge k+2.
- Frame format: 0xAA header, CMD, ARG, CHK, where CHK = CMD ^ ARG.
- FSM states: IDLE, HDR, CMD, ARG, EXEC.
  - IDLE: a strobe with byte 0xAA → HDR. Any other byte is ignored silently.
  - HDR: strobe → latch CMD, go to CMD.
  - CMD: strobe → latch ARG, go to ARG.
  - ARG: on strobe, compare the byte to CMD^ARG.
    - Match with a known CMD → EXEC.
    - Mismatch or unknown CMD → frame_err pulse next cycle, return to IDLE.
  - EXEC: one cycle. Outputs updated, cmd_valid pulses, return to IDLE.
  - Last-byte rx_ready sampled at edge k → outputs and cmd_valid change at edge k+3.
- Command decode (ARG = speed s):
  - 'F' 0x46: dir_l=1, dir_r=1, speed_l=speed_r=s.
  - 'B' 0x42: dir_l=0, dir_r=0, speed_l=speed_r=s.
  - 'L' 0x4C: dir_l=0, dir_r=1, both speeds s.
  - 'R' 0x52: dir_l=1, dir_r=0, both speeds s.
  - 'S' 0x53: dirs 0, speeds 0; ARG ignored but still checksummed.
- Output hold: outputs hold their last value between frames.
- Gap timer:
  - Cleared on every strobe and while in IDLE; counts in HDR, CMD and ARG.
  - On reaching GAP_CYCLES-1 → back to IDLE with no frame_err. Partial bytes are discarded.
- Watchdog:
  - Counts every cycle and is cleared in the EXEC cycle.
  - On reaching TIMEOUT_CYCLES-1: next edge sets timeout=1 and forces speeds 0 and dirs 0. The counter then saturates.
  - timeout clears only in EXEC, at the same edge the new command is applied.
  - A 'S' frame also clears timeout.
- Simultaneous events:
  - EXEC in the same cycle as watchdog expiry → EXEC wins; counter cleared; timeout stays 0.
  - Gap expiry in the same cycle as a strobe → the strobe wins and the byte is accepted.
  - rx_ready that stays high produces exactly one strobe per rising edge.
- Reset mid-frame: the frame is abandoned and outputs are zeroed. A strobe pending in the synchronizer is discarded.

Test Plan:
- Reset, then AA 46 80 C6 → dir_l=dir_r=1, speed_l=speed_r=0x80; one cmd_valid pulse at k+3 after the last rx_ready; frame_err never set.
- AA 4C 40 0C, then AA 53 00 53 → first frame gives dir_l=0, dir_r=1, speeds 0x40; second frame gives all outputs 0, with two cmd_valid pulses.
- Bad checksum AA 46 80 00 → one frame_err pulse, outputs unchanged. Unknown command AA 58 10 48 → frame_err. Stray bytes 12 34 before the header → ignored, no error.
- Small overrides (TIMEOUT_CYCLES=200, GAP_CYCLES=20):
  - AA 46 then a 25-cycle gap then 80 C6 → frame dropped, outputs unchanged.
  - A forward frame, then 200 idle cycles → timeout=1, speeds 0.
  - A new AA 42 20 62 → timeout=0, dirs 0, speeds 0x20.
- rx_ready held high for 100 cycles on one byte → exactly one strobe. Reset (rst=0) asserted after AA 46 → outputs 0, FSM IDLE; a following full frame executes normally.

Source files
------------

// File: rtl/cart_cmd_ctrl.sv
// Cart command sequencer: parses 0xAA/CMD/ARG/CHK frames from the UART
// receiver into motor direction/speed registers, with a link-loss watchdog.
module cart_cmd_ctrl #(
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int GAP_CYCLES     = 5000000,
    parameter int CNT_W          = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       dir_l,
    output logic       dir_r,
    output logic [7:0] speed_l,
    output logic [7:0] speed_r,
    output logic       cmd_valid,
    output logic       frame_err,
    output logic       timeout
);

    localparam logic [CNT_W-1:0] WD_MAX  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_MAX = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, HDR, CMD, ARG, EXEC} state_t;

    state_t           state;
    logic             s1, s2, s3;
    logic [7:0]       cmd_q, arg_q;
    logic [CNT_W-1:0] wd_cnt, gap_cnt;
    logic             strobe;
    logic             cmd_known;

    // rx_ready comes from the baud clock domain; s1/s2 synchronize, s3 edge-detects
    assign strobe = s2 & ~s3;

    always_comb begin
        cmd_known = 1'b0;
        case (cmd_q)
            8'h46, 8'h42, 8'h4C, 8'h52, 8'h53: cmd_known = 1'b1;
            default:                           cmd_known = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            cmd_q     <= 8'h00;
            arg_q     <= 8'h00;
            wd_cnt    <= '0;
            gap_cnt   <= '0;
            dir_l     <= 1'b0;
            dir_r     <= 1'b0;
            speed_l   <= 8'h00;
            speed_r   <= 8'h00;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            s1        <= rx_ready;
            s2        <= s1;
            s3        <= s2;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;

            // Watchdog saturates at expiry and keeps the motors stopped
            if (state == EXEC) begin
                wd_cnt <= '0;
            end else if (wd_cnt == WD_MAX) begin
                timeout <= 1'b1;
                dir_l   <= 1'b0;
                dir_r   <= 1'b0;
                speed_l <= 8'h00;
                speed_r <= 8'h00;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end

            if (strobe || state == IDLE || state == EXEC)
                gap_cnt <= '0;
            else
                gap_cnt <= gap_cnt + 1'b1;

            case (state)
                IDLE: if (strobe && rx_data == 8'hAA) state <= HDR;
                HDR: begin
                    if (strobe) begin
                        cmd_q <= rx_data;
                        state <= CMD;
                    end else if (gap_cnt == GAP_MAX) begin
                        state <= IDLE;
                    end
                end
                CMD: begin
                    if (strobe) begin
                        arg_q <= rx_data;
                        state <= ARG;
                    end else if (gap_cnt == GAP_MAX) begin
                        state <= IDLE;
                    end
                end
                ARG: begin
                    if (strobe) begin
                        if (rx_data == (cmd_q ^ arg_q) && cmd_known) begin
                            state <= EXEC;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end
                    end else if (gap_cnt == GAP_MAX) begin
                        state <= IDLE;
                    end
                end
                EXEC: begin
                    // Placed after the watchdog so a coincident expiry loses
                    state     <= IDLE;
                    cmd_valid <= 1'b1;
                    timeout   <= 1'b0;
                    speed_l   <= arg_q;
                    speed_r   <= arg_q;
                    case (cmd_q)
                        8'h46: begin dir_l <= 1'b1; dir_r <= 1'b1; end
                        8'h42: begin dir_l <= 1'b0; dir_r <= 1'b0; end
                        8'h4C: begin dir_l <= 1'b0; dir_r <= 1'b1; end
                        8'h52: begin dir_l <= 1'b1; dir_r <= 1'b0; end
                        default: begin
                            dir_l   <= 1'b0;
                            dir_r   <= 1'b0;
                            speed_l <= 8'h00;
                            speed_r <= 8'h00;
                        end
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cart_cmd_ctrl.sv
// Scoreboard bench for cart_cmd_ctrl with shortened watchdog/gap timers.
module tb_cart_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0;
    logic       dir_l, dir_r, cmd_valid, frame_err, timeout;
    logic [7:0] speed_l, speed_r;

    cart_cmd_ctrl #(.TIMEOUT_CYCLES(200), .GAP_CYCLES(20), .CNT_W(26)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
        .dir_l(dir_l), .dir_r(dir_r), .speed_l(speed_l), .speed_r(speed_r),
        .cmd_valid(cmd_valid), .frame_err(frame_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int last_valid = 0;

    typedef struct {
        bit         err;
        int         at;
        bit         dl;
        bit         dr;
        logic [7:0] sp;
    } ev_t;
    ev_t sb[$];
    ev_t mon_e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every cmd_valid / frame_err pulse must match the oldest expected event
    always @(negedge clk) begin
        if (rst && (cmd_valid || frame_err)) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", {30'd0, cmd_valid, frame_err}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("ev_kind", {31'd0, frame_err}, {31'd0, mon_e.err});
                chk("ev_cycle", cyc, mon_e.at);
                if (!mon_e.err) begin
                    chk("ev_dir_l", {31'd0, dir_l}, {31'd0, mon_e.dl});
                    chk("ev_dir_r", {31'd0, dir_r}, {31'd0, mon_e.dr});
                    chk("ev_speed_l", {24'd0, speed_l}, {24'd0, mon_e.sp});
                    chk("ev_speed_r", {24'd0, speed_r}, {24'd0, mon_e.sp});
                    last_valid = cyc;
                end
            end
        end
    end

    // Byte held for 3 edges then dropped; when push is set, the event is
    // expected 4 edges (cmd_valid) or 3 edges (frame_err) after the first sample.
    task automatic send_byte(input logic [7:0] b, input bit push, input ev_t e);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        if (push) begin
            e.at = cyc + (e.err ? 3 : 4);
            sb.push_back(e);
        end
        repeat (3) @(negedge clk);
        rx_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] cm, input logic [7:0] ar, input logic [7:0] ck);
        ev_t e;
        ev_t none;
        bit  known;
        none = '{err: 1'b0, at: 0, dl: 1'b0, dr: 1'b0, sp: 8'h00};
        e = none;
        known = 1'b1;
        e.sp = ar;
        case (cm)
            8'h46: begin e.dl = 1'b1; e.dr = 1'b1; end
            8'h42: begin e.dl = 1'b0; e.dr = 1'b0; end
            8'h4C: begin e.dl = 1'b0; e.dr = 1'b1; end
            8'h52: begin e.dl = 1'b1; e.dr = 1'b0; end
            8'h53: e.sp = 8'h00;
            default: known = 1'b0;
        endcase
        e.err = !(known && ck == (cm ^ ar));
        send_byte(8'hAA, 1'b0, none);
        send_byte(cm, 1'b0, none);
        send_byte(ar, 1'b0, none);
        send_byte(ck, 1'b1, e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dir_l", {31'd0, dir_l}, 32'd0);
        chk("rst_dir_r", {31'd0, dir_r}, 32'd0);
        chk("rst_speed_l", {24'd0, speed_l}, 32'd0);
        chk("rst_speed_r", {24'd0, speed_r}, 32'd0);
        chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        rst = 1'b1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    ev_t nil;

    initial begin
        nil = '{err: 1'b0, at: 0, dl: 1'b0, dr: 1'b0, sp: 8'h00};
        do_reset();

        send_frame(8'h46, 8'h80, 8'hC6);
        chk("fwd_dir_l", {31'd0, dir_l}, 32'd1);
        chk("fwd_speed_r", {24'd0, speed_r}, 32'h80);

        send_frame(8'h46, 8'h80, 8'h00);
        chk("badchk_hold_speed", {24'd0, speed_l}, 32'h80);
        chk("badchk_hold_dir", {31'd0, dir_r}, 32'd1);

        send_frame(8'h4C, 8'h40, 8'h0C);
        chk("left_dir_l", {31'd0, dir_l}, 32'd0);
        chk("left_dir_r", {31'd0, dir_r}, 32'd1);
        chk("left_speed", {24'd0, speed_l}, 32'h40);

        send_frame(8'h53, 8'h00, 8'h53);
        chk("stop_outs", {14'd0, dir_l, dir_r, speed_l, speed_r}, 32'd0);

        send_byte(8'h12, 1'b0, nil);
        send_byte(8'h34, 1'b0, nil);
        send_frame(8'h58, 8'h10, 8'h48);

        // Inter-byte gap longer than the gap timer drops the frame silently
        send_frame(8'h46, 8'h80, 8'hC6);
        send_byte(8'hAA, 1'b0, nil);
        send_byte(8'h46, 1'b0, nil);
        repeat (25) @(negedge clk);
        send_byte(8'h80, 1'b0, nil);
        send_byte(8'hC6, 1'b0, nil);
        chk("gap_hold_speed", {24'd0, speed_l}, 32'h80);
        chk("gap_hold_dir", {31'd0, dir_l}, 32'd1);

        wait_until(last_valid + 190);
        chk("wd_not_yet", {31'd0, timeout}, 32'd0);
        wait_until(last_valid + 205);
        chk("wd_timeout", {31'd0, timeout}, 32'd1);
        chk("wd_outs_zero", {14'd0, dir_l, dir_r, speed_l, speed_r}, 32'd0);

        send_frame(8'h42, 8'h20, 8'h62);
        chk("wd_cleared", {31'd0, timeout}, 32'd0);
        chk("back_speed", {24'd0, speed_r}, 32'h20);

        // A level-held rx_ready must strobe only once (else AA,AA,AA -> error)
        do_reset();
        @(negedge clk);
        rx_data  = 8'hAA;
        rx_ready = 1'b1;
        repeat (100) @(negedge clk);
        rx_ready = 1'b0;
        repeat (30) @(negedge clk);
        send_frame(8'h46, 8'h80, 8'hC6);
        chk("held_then_fwd", {24'd0, speed_l}, 32'h80);

        // Reset mid-frame abandons the partial frame
        send_byte(8'hAA, 1'b0, nil);
        send_byte(8'h46, 1'b0, nil);
        do_reset();
        send_frame(8'h52, 8'h30, 8'h62);
        chk("post_rst_dir_l", {31'd0, dir_l}, 32'd1);
        chk("post_rst_dir_r", {31'd0, dir_r}, 32'd0);
        chk("post_rst_speed", {24'd0, speed_l}, 32'h30);

        repeat (10) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
